// File: rtl/bcd_counter_segdis_mux.sv
// bcd_counter_segdis_mux: prescaled multi-digit BCD counter with multiplexed 7-segment display driver
// Ports: mclk clock; rst sync active-high reset; en count enable (gates prescaler and counting only);
//   bcd registered digit vector (digit 0 in [3:0]); carry one-cycle pulse on wrap to all zeros;
//   seg_com active-low one-hot digit select; seg_data {dp,g,f,e,d,c,b,a} active-high segments.
module bcd_counter_segdis_mux #(
  parameter int NUM_DIGITS = 2,
  parameter int TOP_MOD = 6,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                    mclk,
  input  logic                    rst,
  input  logic                    en,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    carry,
  output logic [7:0]              seg_com,
  output logic [7:0]              seg_data
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;
  logic tick, scan_adv;
  logic [NUM_DIGITS:0] cy;
  logic [4*NUM_DIGITS-1:0] bcd_nxt;
  logic [3:0] cur;
  logic [7:0] seg;
  assign tick = en && tick_cnt == TW'(TICK_DIV - 1);
  assign scan_adv = scan_cnt == SW'(SCAN_DIV - 1);
  assign cy[0] = tick;
  // Ripple carry: a digit rolls over only when it is at its maximum and receives a carry-in.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    localparam logic [3:0] MAX = k == NUM_DIGITS - 1 ? 4'(TOP_MOD - 1) : 4'd9;
    logic [3:0] d;
    assign d = bcd[4*k +: 4];
    assign cy[k+1] = cy[k] && d == MAX;
    assign bcd_nxt[4*k +: 4] = !cy[k] ? d : cy[k+1] ? 4'd0 : d + 4'd1;
  end
  assign cur = bcd[{scan_idx, 2'b00} +: 4];
  always_comb begin
    seg = 8'h00;
    case (cur)
      4'd0: seg = 8'h3F;
      4'd1: seg = 8'h06;
      4'd2: seg = 8'h5B;
      4'd3: seg = 8'h4F;
      4'd4: seg = 8'h66;
      4'd5: seg = 8'h6D;
      4'd6: seg = 8'h7D;
      4'd7: seg = 8'h07;
      4'd8: seg = 8'h7F;
      4'd9: seg = 8'h67;
      default: seg = 8'h00;
    endcase
  end
  always_ff @(posedge mclk) begin
    if (rst) begin
      tick_cnt <= '0;
      bcd <= '0;
      carry <= 1'b0;
      scan_cnt <= '0;
      scan_idx <= '0;
      seg_com <= 8'hFE;
      seg_data <= 8'h3F;
    end else begin
      tick_cnt <= !en ? tick_cnt : tick ? '0 : tick_cnt + 1'b1;
      bcd <= bcd_nxt;
      carry <= cy[NUM_DIGITS];
      scan_cnt <= scan_adv ? '0 : scan_cnt + 1'b1;
      scan_idx <= !scan_adv ? scan_idx : scan_idx == IW'(NUM_DIGITS - 1) ? '0 : scan_idx + 1'b1;
      // Display registers sample pre-increment digits, so com and data always agree.
      seg_com <= ~(8'd1 << scan_idx);
      seg_data <= seg;
    end
  end
endmodule

// File: tb/tb_bcd_counter_segdis_mux.sv
// tb_bcd_counter_segdis_mux: scoreboard bench for the BCD counter / display mux
module tb_bcd_counter_segdis_mux;
  logic clk = 0, rst = 1, en = 0, rst1 = 1, en1 = 0;
  logic [7:0] bcd0, com0, dat0, com1, dat1;
  logic [3:0] bcd1;
  logic c0, c1;
  int edges = 0, base = 2, base1 = 0, n_cmp = 0, n_bad = 0;
  typedef struct {
    int cyc;
    int unit;
    logic [3:0] m;
    logic [7:0] b;
    logic c;
    logic [7:0] com;
    logic [7:0] dat;
    logic [63:0] nm;
  } exp_t;
  exp_t q[$];
  logic [7:0] tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h67};

  bcd_counter_segdis_mux #(.NUM_DIGITS(2), .TOP_MOD(6), .TICK_DIV(4), .SCAN_DIV(3)) u0 (
    .mclk(clk), .rst(rst), .en(en), .bcd(bcd0), .carry(c0), .seg_com(com0), .seg_data(dat0));
  bcd_counter_segdis_mux #(.NUM_DIGITS(1), .TOP_MOD(10), .TICK_DIV(1), .SCAN_DIV(1)) u1 (
    .mclk(clk), .rst(rst1), .en(en1), .bcd(bcd1), .carry(c1), .seg_com(com1), .seg_data(dat1));

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic push(int cyc, int unit, logic [3:0] m, logic [7:0] b, logic c,
                      logic [7:0] com, logic [7:0] dat, logic [63:0] nm);
    q.push_back('{cyc, unit, m, b, c, com, dat, nm});
  endtask

  task automatic go(int n);
    while (edges - base < n) @(negedge clk);
  endtask

  function automatic logic [7:0] com_at(int m);
    return ((m - 1) / 3) % 2 == 0 ? 8'hFE : 8'hFD;
  endfunction

  function automatic void cmp(logic [63:0] nm, string f, int cyc, logic [7:0] a, logic [7:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %0s.%0s @%0d: got %h want %h", nm, f, cyc, a, e);
    end
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #2;
    while (q.size() > 0 && q[0].cyc <= edges) begin
      e = q.pop_front();
      if (e.cyc < edges) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %0s missed @%0d", e.nm, e.cyc);
      end else begin
        if (e.m[3]) cmp(e.nm, "bcd", e.cyc, e.unit != 0 ? {4'h0, bcd1} : bcd0, e.b);
        if (e.m[2]) cmp(e.nm, "carry", e.cyc, {7'd0, e.unit != 0 ? c1 : c0}, {7'd0, e.c});
        if (e.m[1]) cmp(e.nm, "com", e.cyc, e.unit != 0 ? com1 : com0, e.com);
        if (e.m[0]) cmp(e.nm, "data", e.cyc, e.unit != 0 ? dat1 : dat0, e.dat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    push(2, 0, 4'hF, 8'h00, 1'b0, 8'hFE, 8'h3F, "reset");
    repeat (2) @(negedge clk);
    rst = 0;
    en = 1;
    push(base + 36, 0, 4'h8, 8'h09, 1'b0, 8'h00, 8'h00, "dec09");
    push(base + 40, 0, 4'h8, 8'h10, 1'b0, 8'h00, 8'h00, "dec10");
    push(base + 239, 0, 4'hC, 8'h59, 1'b0, 8'h00, 8'h00, "prewrap");
    push(base + 240, 0, 4'hC, 8'h00, 1'b1, 8'h00, 8'h00, "wrap");
    push(base + 241, 0, 4'hC, 8'h00, 1'b0, 8'h00, 8'h00, "postwrap");
    go(334);
    en = 0;
    push(base + 335, 0, 4'h8, 8'h23, 1'b0, 8'h00, 8'h00, "gate_bcd");
    for (int m = 335; m <= 340; m++) push(base + m, 0, 4'h2, 8'h00, 1'b0, com_at(m), 8'h00, "gate_com");
    push(base + 345, 0, 4'h8, 8'h23, 1'b0, 8'h00, 8'h00, "gate_bcd");
    push(base + 354, 0, 4'h8, 8'h23, 1'b0, 8'h00, 8'h00, "gate_bcd");
    push(base + 355, 0, 4'h8, 8'h23, 1'b0, 8'h00, 8'h00, "resume1");
    push(base + 356, 0, 4'h8, 8'h24, 1'b0, 8'h00, 8'h00, "resume2");
    go(354);
    en = 1;
    push(base + 428, 0, 4'h8, 8'h42, 1'b0, 8'h00, 8'h00, "at42");
    go(428);
    en = 0;
    for (int m = 429; m <= 440; m++)
      push(base + m, 0, 4'hB, 8'h42, 1'b0, com_at(m), com_at(m) == 8'hFE ? 8'h5B : 8'h66, "scan");
    go(441);
    en = 1;
    push(base + 509, 0, 4'h8, 8'h59, 1'b0, 8'h00, 8'h00, "at59");
    push(base + 512, 0, 4'hC, 8'h59, 1'b0, 8'h00, 8'h00, "prerst");
    push(base + 513, 0, 4'hF, 8'h00, 1'b0, 8'hFE, 8'h3F, "midrst");
    push(base + 514, 0, 4'hF, 8'h00, 1'b0, 8'hFE, 8'h3F, "postrst");
    go(512);
    rst = 1;
    go(513);
    rst = 0;
    en = 0;
    go(520);
    base1 = edges;
    for (int k = 1; k <= 25; k++)
      push(base1 + k, 1, 4'hF, 8'(k % 10), k % 10 == 0, 8'hFE, tab[(k - 1) % 10], "u1");
    rst1 = 0;
    en1 = 1;
    go(550);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_counter_segdis_mux.md
Name: bcd_counter_segdis_mux

Overview:
Parametrised multi-digit BCD counter with a time-multiplexed 7-segment display driver.
- Internal prescaler advances the count from mclk.
- Scan divider cycles through the digits on the shared seg_data bus, with one seg_com line per digit.
- Lower digits count mod 10. The most-significant digit has a configurable modulus (default 00..59, i.e. seconds display).
- Provides a wrap carry so instances can be chained (e.g. minutes after seconds).

Parameters:
NUM_DIGITS, 2, number of BCD digits counted and scanned; legal 1..8
TOP_MOD, 6, modulus of most-significant digit; legal 2..10
TICK_DIV, 50000000, mclk cycles per count increment; legal >=1 (1 = increment every enabled cycle)
SCAN_DIV, 50000, mclk cycles each digit is displayed before advancing; legal >=1

Ports:
mclk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  count enable; gates prescaler and counting only
bcd  out  4*NUM_DIGITS  current count; digit k at bits [4k+3:4k], digit 0 = least significant
carry  out  1  one-cycle pulse when count wraps from max to all zeros
seg_com  out  8  digit select, active-low one-hot; bits >= NUM_DIGITS held 1
seg_data  out  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high, dp always 0

Behaviour:
Reset (rst=1 at a clock edge):
- Overrides en, tick and scan.
- Next cycle: prescaler=0, all digits=0, scan counter=0, scan index=0, carry=0, seg_com=8'hFE, seg_data=8'h3F.

Prescaler:
- tick_cnt runs 0..TICK_DIV-1 while en=1 and holds while en=0.
- tick is an internal single-cycle strobe, asserted when en=1 and tick_cnt==TICK_DIV-1; tick_cnt returns to 0 on that cycle.
- TICK_DIV=1: tick every cycle en=1.

Counter (updates on the edge where tick=1):
- Digit 0 increments.
- Digit k for k<NUM_DIGITS-1: when it is 9 and receives a carry-in, it becomes 0 and passes a carry to digit k+1.
- Top digit: when it is TOP_MOD-1 and receives a carry-in, it becomes 0.
- NUM_DIGITS=1: digit 0 is the top digit and uses TOP_MOD.
- bcd is the registered digit vector, no additional latency; digits never hold values >9 or >=TOP_MOD (top digit).

Carry:
- Registered; high for exactly one cycle, the same cycle bcd first reads all zeros after a wrap.
- Low otherwise, including after reset.

Scanner (independent of en):
- scan_cnt runs 0..SCAN_DIV-1.
- At terminal count, scan_idx advances 0..NUM_DIGITS-1 and wraps to 0.

Display outputs:
- seg_com and seg_data are registered every cycle from the current scan_idx and digit values: 1-cycle latency and always mutually consistent.
- seg_com bit scan_idx=0, all other bits 1.
- seg_data decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67
  - any other value = 00 (blank, never X)

Simultaneous events:
- A tick and a scan advance in the same cycle both take effect.
- The displayed digit reflects pre-increment values for that cycle and is updated the next cycle.

Widths:
- tick_cnt and scan_cnt use clog2 widths.
- Counters must not overflow for any legal parameter values.

Test Plan:
1. Reset, NUM_DIGITS=2, TOP_MOD=6, TICK_DIV=4, SCAN_DIV=3 (used for all cases below): rst high 2 cycles then low -> bcd=8'h00, carry=0, seg_com=8'hFE, seg_data=8'h3F on first post-reset cycle.
2. Decade rollover: en=1 for 40 cycles from reset -> bcd=8'h10 exactly at cycle 40; bcd=8'h09 at cycle 36.
3. Full wrap: en=1 for 240 cycles -> bcd goes 8'h59 -> 8'h00 at cycle 240; carry=1 on that cycle only, 0 at 239 and 241.
4. Enable gating: drop en at bcd=8'h23 with tick_cnt=2 for 20 cycles -> bcd holds 8'h23 and tick_cnt holds 2; seg_com keeps alternating; after en returns, next increment arrives 2 cycles later.
5. Scan/decode: hold bcd=8'h42 (en=0) -> seg_com alternates FE/FD every 3 cycles; seg_data=8'h5B while FE, 8'h66 while FD; bits [7:2] of seg_com always 1.
6. Reset mid-operation: assert rst on a tick cycle with bcd=8'h59 -> next cycle bcd=8'h00, carry=0 (no wrap pulse), seg_com=8'hFE; also run TICK_DIV=1, NUM_DIGITS=1, TOP_MOD=10 -> bcd cycles 0..9 every cycle, carry pulses every 10 cycles.
